// File: rtl/baud_tick_gen.sv
// baud_tick_gen: multi-channel fractional baud-tick generator on the 50 MHz
// reference clock. Each channel runs a phase accumulator whose carry is the
// oversample tick; every OVERSAMPLE ticks a bit tick is emitted. Channel rates
// are reprogrammed through a write/ack port and applied on the next carry so
// the phase stays continuous.
// Optional feature: define BAUD_TICK_PHASE_SYNC_EN to add the phase_sync input
// that realigns the phase of every channel at once.
module baud_tick_gen #(
  parameter int          NUM_CH     = 2,
  parameter int          ACC_W      = 32,
  parameter int          OVERSAMPLE = 16,
  parameter int unsigned DEF_INC    = 158329674
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
`ifdef BAUD_TICK_PHASE_SYNC_EN
  input  logic              phase_sync,
`endif
  input  logic              inc_wr,
  input  logic [2:0]        inc_ch,
  input  logic [ACC_W-1:0]  inc_data,
  output logic              inc_ack,
  output logic              inc_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] bit_tick,
  output logic [NUM_CH-1:0] locked
);

  localparam int               OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       CH_LIM  = 4'(NUM_CH);
  localparam logic [ACC_W-1:0] INC_RST = ACC_W'(DEF_INC);

  logic sync;
  logic wr_ok;

`ifdef BAUD_TICK_PHASE_SYNC_EN
  assign sync = phase_sync;
`else
  assign sync = 1'b0;
`endif

  // A write is legal for an existing channel and an increment below half scale,
  // which keeps every channel's tick rate under refclk/2.
  always_comb begin
    wr_ok = inc_wr && ({1'b0, inc_ch} < CH_LIM) && !inc_data[ACC_W-1];
  end

  // Every write is acknowledged one cycle later; rejected ones also flag an error.
  always_ff @(posedge refclk) begin
    if (rst) begin
      inc_ack <= 1'b0;
      inc_err <= 1'b0;
    end else begin
      inc_ack <= inc_wr;
      inc_err <= inc_wr && !wr_ok;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_act;
    logic [ACC_W-1:0] inc_pend;
    logic             pend;
    logic [OS_W-1:0]  os_cnt;
    logic [OS_W-1:0]  lock_cnt;
    logic             tick_r;
    logic             bit_r;
    logic             lock_r;
    logic [ACC_W:0]   sum;
    logic             run;
    logic             carry;
    logic             wr_hit;

    // Accumulator add and per-channel decode of the write port.
    always_comb begin
      run    = en[c] && (inc_act != '0);
      sum    = {1'b0, acc} + {1'b0, inc_act};
      carry  = run && sum[ACC_W] && !sync;
      wr_hit = wr_ok && (inc_ch == 3'(c));
    end

    // Phase accumulator, oversample counter, rate update and lock tracking.
    always_ff @(posedge refclk) begin
      if (rst) begin
        acc      <= '0;
        inc_act  <= INC_RST;
        inc_pend <= '0;
        pend     <= 1'b0;
        os_cnt   <= '0;
        lock_cnt <= '0;
        tick_r   <= 1'b0;
        bit_r    <= 1'b0;
        lock_r   <= 1'b0;
      end else begin
        // Disabled or realigned channels restart from phase 0.
        if (!en[c] || sync) begin
          acc    <= '0;
          os_cnt <= '0;
          tick_r <= 1'b0;
          bit_r  <= 1'b0;
        end else if (run) begin
          acc    <= sum[ACC_W-1:0];
          tick_r <= carry;
          bit_r  <= carry && (os_cnt == OS_LAST);
          if (carry) begin
            os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
          end
        end else begin
          tick_r <= 1'b0;
          bit_r  <= 1'b0;
        end

        // The pending rate takes over on a carry, keeping the residual phase;
        // a stopped channel has no phase to protect and takes it at once.
        if (pend && (!run || carry)) begin
          inc_act <= inc_pend;
          pend    <= 1'b0;
        end
        // A write in the same cycle as an apply becomes the next pending value.
        if (wr_hit) begin
          inc_pend <= inc_data;
          pend     <= 1'b1;
        end

        // Lock counts carries at the committed rate only.
        if (wr_hit || !run) begin
          lock_r   <= 1'b0;
          lock_cnt <= '0;
        end else if (carry && !pend && !lock_r) begin
          if (lock_cnt == OS_LAST) begin
            lock_r <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + OS_W'(1);
          end
        end
      end
    end

    assign tick[c]     = tick_r;
    assign bit_tick[c] = bit_r;
    assign locked[c]   = lock_r;
  end

endmodule
